// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
// Holds the PC increment, the saturating-counter encodings and the
// index/tag width helpers used by every predictor file.
package branch_predictor_pkg;

  localparam int unsigned PC_INC = 4;

  // Index bits sit directly above the two byte-offset bits of the PC.
  function automatic int unsigned idx_width(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

  // Weakly-taken: MSB set, remaining bits clear.
  function automatic int unsigned cnt_weak_taken(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, remaining bits set.
  function automatic int unsigned cnt_weak_not_taken(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: combinational next value of a CNT_W-bit saturating
// up/down counter.
// Ports:
//   cnt      current counter value
//   up       1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   cnt_next resulting counter value
module bp_sat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (up) begin
      if (cnt != '1) cnt_next = cnt + 1'b1;
    end else begin
      if (cnt != '0) cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters and lookup/mispredict statistics.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   lookup_valid_i, pc_i         IF-stage lookup request and fetch PC
//   pred_taken_o, pred_target_o  combinational prediction for pc_i
//   upd_*                        resolved branch from MEM (outcome, target,
//                                and the prediction carried down the pipe)
//   clear_i                      invalidate all entries
//   mispredict_o, redirect_pc_o  flush request and correct next PC
//   stat_lookups_o, stat_mispred_o  saturating statistics counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic              clear_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);
  localparam int unsigned TAG_W = tag_width(ADDR_W, ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0]  CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));
  localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [STAT_W-1:0] stat_lookups_q;
  logic [STAT_W-1:0] stat_mispred_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CNT_W-1:0] up_cnt_next;

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign lk_idx        = pc_i[IDX_W+1:2];
  assign lk_tag        = pc_i[ADDR_W-1:IDX_W+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_i + INC;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_upd_cnt (
    .cnt      (cnt_q[up_idx]),
    .up       (upd_taken_i),
    .cnt_next (up_cnt_next)
  );

  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + INC;

  assign stat_lookups_o = stat_lookups_q;
  assign stat_mispred_o = stat_mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (lookup_valid_i && (stat_lookups_q != '1))
        stat_lookups_q <= stat_lookups_q + 1'b1;
      if (mispredict_o && (stat_mispred_q != '1))
        stat_mispred_q <= stat_mispred_q + 1'b1;

      if (clear_i) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
          cnt_q[i]   <= CNT_WNT;
        end
      end else if (upd_valid_i) begin
        if (up_hit) begin
          cnt_q[up_idx] <= up_cnt_next;
          if (upd_taken_i) target_q[up_idx] <= upd_target_i;
        end else if (upd_taken_i) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target_i;
          cnt_q[up_idx]    <= CNT_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic, all compared against a table model using integer counters.
// A second instance with 4-bit statistics checks counter saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        clear;

  logic        pred_taken,  s_pred_taken;
  logic [31:0] pred_target, s_pred_target;
  logic        mispredict,  s_mispredict;
  logic [31:0] redirect_pc, s_redirect_pc;
  logic [15:0] stat_lookups, stat_mispred;
  logic [3:0]  s_stat_lookups, s_stat_mispred;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES (16), .ADDR_W (32), .CNT_W (2), .STAT_W (16)
  ) u_dut (
    .clk_i (clk), .rst_i (rst),
    .lookup_valid_i (lookup_valid), .pc_i (pc),
    .pred_taken_o (pred_taken), .pred_target_o (pred_target),
    .upd_valid_i (upd_valid), .upd_pc_i (upd_pc), .upd_target_i (upd_target),
    .upd_taken_i (upd_taken), .upd_pred_taken_i (upd_pred_taken),
    .upd_pred_target_i (upd_pred_target), .clear_i (clear),
    .mispredict_o (mispredict), .redirect_pc_o (redirect_pc),
    .stat_lookups_o (stat_lookups), .stat_mispred_o (stat_mispred)
  );

  branch_predictor #(
    .ENTRIES (16), .ADDR_W (32), .CNT_W (2), .STAT_W (4)
  ) u_sat (
    .clk_i (clk), .rst_i (rst),
    .lookup_valid_i (lookup_valid), .pc_i (pc),
    .pred_taken_o (s_pred_taken), .pred_target_o (s_pred_target),
    .upd_valid_i (upd_valid), .upd_pc_i (upd_pc), .upd_target_i (upd_target),
    .upd_taken_i (upd_taken), .upd_pred_taken_i (upd_pred_taken),
    .upd_pred_target_i (upd_pred_target), .clear_i (clear),
    .mispredict_o (s_mispredict), .redirect_pc_o (s_redirect_pc),
    .stat_lookups_o (s_stat_lookups), .stat_mispred_o (s_stat_mispred)
  );

  // Reference table: counter is a plain integer 0..3, taken when >= 2.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_cnt   [16];
  int          m_lookups;
  int          m_mispred;
  bit          m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_idx(input bit [31:0] a);
    return (a / 4) % 16;
  endfunction

  function automatic bit m_hit(input bit [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / 64);
  endfunction

  function automatic bit m_pred(input bit [31:0] a);
    return m_hit(a) && (m_cnt[m_idx(a)] >= 2);
  endfunction

  function automatic bit [31:0] m_target(input bit [31:0] a);
    return m_pred(a) ? m_tgt[m_idx(a)] : a + 32'd4;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit m_mispredict();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  // One clock cycle: inputs are already applied; check, clock, advance model.
  task automatic tick();
    bit mp;
    int unsigned i;
    #4;
    mp = m_mispredict();
    check("mispredict", {31'd0, mispredict}, {31'd0, mp});
    check("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    if (m_known) begin
      check("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(pc)});
      check("pred_target", pred_target, m_target(pc));
      check("stat_lookups", {16'd0, stat_lookups}, sat(m_lookups, 65535));
      check("stat_mispred", {16'd0, stat_mispred}, sat(m_mispred, 65535));
      check("sat_lookups", {28'd0, s_stat_lookups}, sat(m_lookups, 15));
      check("sat_mispred", {28'd0, s_stat_mispred}, sat(m_mispred, 15));
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = '0; m_cnt[k] = 1;
      end
      m_lookups = 0;
      m_mispred = 0;
      m_known   = 1'b1;
    end else begin
      if (lookup_valid) m_lookups++;
      if (mp) m_mispred++;
      if (clear) begin
        for (int k = 0; k < 16; k++) begin
          m_valid[k] = 1'b0; m_cnt[k] = 1;
        end
      end else if (upd_valid) begin
        i = m_idx(upd_pc);
        if (m_hit(upd_pc)) begin
          m_cnt[i] = upd_taken ? sat(m_cnt[i] + 1, 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
          if (upd_taken) m_tgt[i] = upd_target;
        end else if (upd_taken) begin
          m_valid[i] = 1'b1; m_tag[i] = upd_pc / 64; m_tgt[i] = upd_target; m_cnt[i] = 2;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; lookup_valid = 0; pc = '0; upd_valid = 0; upd_pc = '0;
    upd_target = '0; upd_taken = 0; upd_pred_taken = 0; upd_pred_target = '0;
    clear = 0;
  endtask

  task automatic set_upd(input bit [31:0] a, input bit tk, input bit [31:0] tgt,
                         input bit ptk, input bit [31:0] ptgt);
    upd_valid = 1; upd_pc = a; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  function automatic bit [31:0] rand_pc();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'hFFFF_FFFC;
      default: return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
    endcase
  endfunction

  initial begin
    idle();
    rst = 1;
    tick();

    // Reset then lookup 0x40.
    idle(); lookup_valid = 1; pc = 32'h40;
    #1;
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'h44);
    tick();
    idle();
    #1;
    check("first_lookup_stat", {16'd0, stat_lookups}, 32'd1);
    tick();

    // Allocate 0x40 with a wrong not-taken prediction.
    idle(); set_upd(32'h40, 1, 32'h100, 0, 32'h44);
    #1;
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h100);
    tick();
    idle(); lookup_valid = 1; pc = 32'h40;
    #1;
    check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_pred_target", pred_target, 32'h100);
    tick();

    // Three not-taken updates: 2 -> 1 -> 0 -> 0, lookups alongside.
    for (int n = 0; n < 3; n++) begin
      idle(); lookup_valid = 1; pc = 32'h40;
      set_upd(32'h40, 0, 32'h100, n == 0, 32'h100);
      #1;
      if (n == 0) check("wrong_taken_redirect", redirect_pc, 32'h44);
      tick();
    end
    idle(); lookup_valid = 1; pc = 32'h40;
    #1;
    check("saturated_nt", {31'd0, pred_taken}, 32'd0);
    tick();

    // Same index, different tag replaces the occupant.
    idle(); set_upd(32'h40, 1, 32'h200, 0, 32'h44); tick();
    idle(); set_upd(32'h80, 1, 32'h300, 0, 32'h84); tick();
    idle(); lookup_valid = 1; pc = 32'h40;
    #1;
    check("alias_old_miss", {31'd0, pred_taken}, 32'd0);
    tick();
    idle(); lookup_valid = 1; pc = 32'h80;
    #1;
    check("alias_new_target", pred_target, 32'h300);
    tick();

    // Same-cycle update and lookup return the old state.
    idle(); lookup_valid = 1; pc = 32'h80; set_upd(32'h80, 1, 32'h400, 1, 32'h300);
    #1;
    check("bypass_old_target", pred_target, 32'h300);
    tick();

    // Clear wins over a simultaneous taken update; stats untouched.
    idle(); clear = 1; set_upd(32'h80, 1, 32'h400, 1, 32'h400); tick();
    idle(); lookup_valid = 1; pc = 32'h80;
    #1;
    check("clear_empty", {31'd0, pred_taken}, 32'd0);
    tick();

    // Saturate the 4-bit lookup counter.
    idle(); rst = 1; tick();
    for (int n = 0; n < 20; n++) begin
      idle(); lookup_valid = 1; pc = rand_pc(); tick();
    end
    idle();
    #1;
    check("stat4_saturate", {28'd0, s_stat_lookups}, 32'd15);
    tick();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      bit [31:0] a;
      idle();
      rst          = ($urandom_range(0, 199) == 0);
      clear        = ($urandom_range(0, 49) == 0);
      lookup_valid = $urandom_range(0, 1);
      pc           = rand_pc();
      if ($urandom_range(0, 3) != 0) begin
        a = rand_pc();
        if ($urandom_range(0, 1) == 1)
          set_upd(a, $urandom_range(0, 1), 32'h1000 + ($urandom_range(0, 3) << 4),
                  m_pred(a), m_target(a));
        else
          set_upd(a, $urandom_range(0, 1), 32'h1000 + ($urandom_range(0, 3) << 4),
                  $urandom_range(0, 1), 32'h1000 + ($urandom_range(0, 3) << 4));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
